// File: rtl/mux_4ch_rr_sched.sv
// mux_4ch_rr_sched
//   Shares one mux_4ch datapath among four sample sources. A source is
//   granted for a burst of BURST_LEN samples. The scheduler drives the mux
//   select, the per-beat transfer strobe, and a valid/last pair that lines up
//   with the mux's one-cycle registered output.
//
// Build option:
//   MUX_SCHED_FIXED_PRI_EN - when defined, arbitration uses fixed priority
//   (req[0] highest) and there is no round-robin pointer. When undefined
//   (the default), arbitration is round-robin.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   req[3:0]     per-source request; held high for the whole burst
//   dn_ready     downstream accepts a sample this cycle
//   gnt[3:0]     registered one-hot grant; 0 when idle
//   sel[1:0]     registered mux select; holds its last value when idle
//   xfer         combinational; the granted sample is consumed this cycle
//   out_vld      registered xfer; qualifies the mux output
//   out_last     registered; high with out_vld on the final beat of a burst
//   burst_abort  registered one-cycle pulse; the owner dropped req mid-burst
//   dbg_state_o  current FSM state (0 = IDLE, 1 = BURST)
//
// Handshake: a beat transfers in any BURST cycle where req[owner] and
// dn_ready are both high (xfer). There is no back-pressure into the source
// beyond dn_ready; the source must keep req high until its burst ends.

module mux_4ch_rr_sched #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       dn_ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       xfer,
    output logic       out_vld,
    output logic       out_last,
    output logic       burst_abort,
    output logic       dbg_state_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             abort_q, abort_d;
    logic             xfer_c;
    logic             take_grant;

    logic [1:0]       arb_start;
    logic [1:0]       arb_cand;
    logic [1:0]       arb_win;
    logic             arb_found;

`ifdef MUX_SCHED_FIXED_PRI_EN
    assign arb_start = 2'd0;
`else
    logic [1:0] rr_ptr_q;

    // The pointer always sits one past the last winner, so a re-arbitration
    // at the end of a burst naturally starts at owner+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else if (take_grant) begin
            rr_ptr_q <= arb_win + 2'd1;
        end
    end

    assign arb_start = rr_ptr_q;
`endif

    // First set request found scanning upward from arb_start, wrapping 3->0.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = 2'd0;
        arb_cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            arb_cand = arb_start + 2'(k);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_win   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        beat_d     = beat_q;
        vld_d      = 1'b0;
        last_d     = 1'b0;
        abort_d    = 1'b0;
        xfer_c     = 1'b0;
        take_grant = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    take_grant = 1'b1;
                end
            end
            S_BURST: begin
                // Losing the owner's request wins over any transfer.
                if (!req[sel_q]) begin
                    abort_d = 1'b1;
                    gnt_d   = 4'b0000;
                    state_d = S_IDLE;
                end else if (dn_ready) begin
                    xfer_c = 1'b1;
                    vld_d  = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        last_d = 1'b1;
                        // Back-to-back grant with no idle bubble if anyone asks.
                        if (arb_found) begin
                            take_grant = 1'b1;
                        end else begin
                            gnt_d   = 4'b0000;
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = S_IDLE;
            end
        endcase

        if (take_grant) begin
            state_d = S_BURST;
            sel_d   = arb_win;
            gnt_d   = 4'b0001 << arb_win;
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            beat_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            abort_q <= abort_d;
        end
    end

    assign gnt         = gnt_q;
    assign sel         = sel_q;
    assign xfer        = xfer_c;
    assign out_vld     = vld_q;
    assign out_last    = last_q;
    assign burst_abort = abort_q;
    assign dbg_state_o = state_q;

endmodule
